rbzero_vec_loader: RTL and testbench

// SPI-driven configuration controller for the raybox-zero view vectors.

---
 rtl/rbzero_vec_loader_if.sv | 36 +++
 rtl/rbzero_vec_loader.sv | 143 ++++++++++++++
 tb/tb_rbzero_vec_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rbzero_vec_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rbzero_vec_loader_if
// Description : SPI pins, commit strobe and view-vector outputs of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface rbzero_vec_loader_if #(
  parameter int W = 16
);
  logic         i_sclk;
  logic         i_mosi;
  logic         i_ss_n;
  logic         i_commit;
  logic [W-1:0] o_pos_x;
  logic [W-1:0] o_pos_y;
  logic [W-1:0] o_fac_x;
  logic [W-1:0] o_fac_y;
  logic [W-1:0] o_vp_x;
  logic [W-1:0] o_vp_y;
  logic [2:0]   o_pending;
  logic         o_busy;
  logic         o_err;

  modport slave (
    input  i_sclk, i_mosi, i_ss_n, i_commit,
    output o_pos_x, o_pos_y, o_fac_x, o_fac_y, o_vp_x, o_vp_y,
    output o_pending, o_busy, o_err
  );

  modport master (
    output i_sclk, i_mosi, i_ss_n, i_commit,
    input  o_pos_x, o_pos_y, o_fac_x, o_fac_y, o_vp_x, o_vp_y,
    input  o_pending, o_busy, o_err
  );
endinterface
`default_nettype wire

// File: rtl/rbzero_vec_loader.sv
`default_nettype none
// ============================================================================
// Module      : rbzero_vec_loader
// Description : SPI-loaded shadow registers for the view vectors, committed
//               atomically to the tracer on the vblank pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rbzero_vec_loader #(
  parameter int           W        = 16,
  parameter logic [W-1:0] POSX_RST = 16'h0B00,
  parameter logic [W-1:0] POSY_RST = 16'h0B00,
  parameter logic [W-1:0] FACX_RST = 16'h0000,
  parameter logic [W-1:0] FACY_RST = 16'h0100,
  parameter logic [W-1:0] VPX_RST  = 16'h0080,
  parameter logic [W-1:0] VPY_RST  = 16'h0000
) (
  input wire logic                clk,
  input wire logic                rst_n,
  rbzero_vec_loader_if.slave      bus
);
  localparam int           C_FRAME_BITS = 2 + 2 * W;
  localparam int           C_CW         = $clog2(C_FRAME_BITS + 2);
  localparam logic [C_CW-1:0] C_CNT_FULL = C_CW'(C_FRAME_BITS);
  localparam logic [C_CW-1:0] C_CNT_SAT  = C_CW'(C_FRAME_BITS + 1);
  localparam logic [W-1:0] C_RST_X [3] = '{POSX_RST, FACX_RST, VPX_RST};
  localparam logic [W-1:0] C_RST_Y [3] = '{POSY_RST, FACY_RST, VPY_RST};

  logic [2:0]              r_sclk_sync;
  logic [2:0]              r_ss_sync;
  logic [1:0]              r_mosi_sync;
  logic [C_CW-1:0]         r_cnt;
  logic [C_FRAME_BITS-1:0] r_shift;
  logic                    r_end_ok;
  logic                    r_end_bad;
  logic                    r_err;
  logic [2:0]              r_pending;
  logic [W-1:0]            r_live_x [3];
  logic [W-1:0]            r_live_y [3];
  logic [W-1:0]            r_shad_x [3];
  logic [W-1:0]            r_shad_y [3];

  logic       w_sclk_rise;
  logic       w_ss_fall;
  logic       w_ss_rise;
  logic       w_frame_ok;
  logic [1:0] w_cmd;
  logic [2:0] w_stage;
  logic [2:0] w_commit;

  // Edges are taken between the 2nd and 3rd flops so mosi (two flops) is aligned.
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_cmd       = r_shift[C_FRAME_BITS-1 -: 2];
  assign w_frame_ok  = (r_cnt == C_CNT_FULL) && (w_cmd != 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= 3'b000;
      r_ss_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], bus.i_sclk};
      r_ss_sync   <= {r_ss_sync[1:0], bus.i_ss_n};
      r_mosi_sync <= {r_mosi_sync[0], bus.i_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_end_ok  <= 1'b0;
      r_end_bad <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_end_ok  <= 1'b0;
      r_end_bad <= 1'b0;
      r_err     <= r_end_bad;
      if (w_ss_fall) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_sclk_rise && !r_ss_sync[1]) begin
        r_shift <= {r_shift[C_FRAME_BITS-2:0], r_mosi_sync[1]};
        if (r_cnt != C_CNT_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // A select toggle with no clocks is neither staged nor flagged.
      if (w_ss_rise) begin
        r_end_ok  <= w_frame_ok;
        r_end_bad <= !w_frame_ok && (r_cnt != '0);
      end
    end
  end

  always_comb begin
    w_stage  = 3'b000;
    w_commit = 3'b000;
    for (int g = 0; g < 3; g++) begin
      w_stage[g]  = r_end_ok && (w_cmd == 2'(g));
      w_commit[g] = bus.i_commit && r_pending[g];
    end
  end

  // Commit reads the old shadow, so a same-cycle stage waits for the next vblank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 3'b000;
      for (int g = 0; g < 3; g++) begin
        r_live_x[g] <= C_RST_X[g];
        r_live_y[g] <= C_RST_Y[g];
        r_shad_x[g] <= C_RST_X[g];
        r_shad_y[g] <= C_RST_Y[g];
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (w_commit[g]) begin
          r_live_x[g] <= r_shad_x[g];
          r_live_y[g] <= r_shad_y[g];
        end
        if (w_stage[g]) begin
          r_shad_x[g]  <= r_shift[2*W-1:W];
          r_shad_y[g]  <= r_shift[W-1:0];
          r_pending[g] <= 1'b1;
        end else if (w_commit[g]) begin
          r_pending[g] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_pos_x   = r_live_x[0];
  assign bus.o_pos_y   = r_live_y[0];
  assign bus.o_fac_x   = r_live_x[1];
  assign bus.o_fac_y   = r_live_y[1];
  assign bus.o_vp_x    = r_live_x[2];
  assign bus.o_vp_y    = r_live_y[2];
  assign bus.o_pending = r_pending;
  assign bus.o_busy    = ~r_ss_sync[1];
  assign bus.o_err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_rbzero_vec_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbzero_vec_loader
// Description : Directed and random SPI frames against a shadow/live model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbzero_vec_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  rbzero_vec_loader_if #(.W(16)) bus ();
  rbzero_vec_loader #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] m_live_x [3];
  logic [15:0] m_live_y [3];
  logic [15:0] m_sh_x   [3];
  logic [15:0] m_sh_y   [3];
  logic [2:0]  m_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_live_x = '{16'h0B00, 16'h0000, 16'h0080};
    m_live_y = '{16'h0B00, 16'h0100, 16'h0000};
    m_sh_x   = m_live_x;
    m_sh_y   = m_live_y;
    m_pend   = 3'b000;
  endtask

  task automatic model_commit();
    for (int g = 0; g < 3; g++) begin
      if (m_pend[g]) begin
        m_live_x[g] = m_sh_x[g];
        m_live_y[g] = m_sh_y[g];
        m_pend[g]   = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pos_x"}, 64'(bus.o_pos_x), 64'(m_live_x[0]));
    chk({tag, ".pos_y"}, 64'(bus.o_pos_y), 64'(m_live_y[0]));
    chk({tag, ".fac_x"}, 64'(bus.o_fac_x), 64'(m_live_x[1]));
    chk({tag, ".fac_y"}, 64'(bus.o_fac_y), 64'(m_live_y[1]));
    chk({tag, ".vp_x"},  64'(bus.o_vp_x),  64'(m_live_x[2]));
    chk({tag, ".vp_y"},  64'(bus.o_vp_y),  64'(m_live_y[2]));
    chk({tag, ".pending"}, 64'(bus.o_pending), 64'(m_pend));
  endtask

  task automatic commit(input string tag);
    @(negedge clk);
    bus.i_commit = 1'b1;
    @(posedge clk);
    #1;
    bus.i_commit = 1'b0;
    model_commit();
    check_all(tag);
  endtask

  // nbits of {cmd,x,y,filler} are sent MSB first; abort_at < nbits resets mid-frame.
  task automatic send_frame(input string tag, input int nbits, input logic [1:0] cmd,
                            input logic [15:0] x, input logic [15:0] y,
                            input bit commit_at_end, input int abort_at);
    logic [63:0] d;
    bit          valid;
    d = {cmd, x, y, 30'($urandom)};
    @(negedge clk);
    bus.i_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.i_ss_n = 1'b1;
        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all({tag, ".rst"});
        for (int k = 0; k < 6; k++) begin
          @(posedge clk);
          #1;
          chk({tag, ".noerr"}, 64'(bus.o_err), 64'(0));
        end
        return;
      end
      bus.i_mosi = d[63-i];
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_sclk = 1'b0;
      if (i == 0) chk({tag, ".busy"}, 64'(bus.o_busy), 64'(1));
    end
    repeat (4) @(negedge clk);
    bus.i_ss_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".pend_early"}, 64'(bus.o_pending), 64'(m_pend));
    if (commit_at_end) bus.i_commit = 1'b1;
    @(posedge clk);
    #1;
    bus.i_commit = 1'b0;
    valid = (nbits == 34) && (cmd != 2'b11);
    if (commit_at_end) model_commit();
    if (valid) begin
      m_sh_x[cmd] = x;
      m_sh_y[cmd] = y;
      m_pend[cmd] = 1'b1;
    end
    check_all(tag);
    chk({tag, ".err"}, 64'(bus.o_err), 64'(!valid && nbits != 0));
    chk({tag, ".busy_end"}, 64'(bus.o_busy), 64'(0));
    @(posedge clk);
    #1;
    chk({tag, ".err_gone"}, 64'(bus.o_err), 64'(0));
  endtask

  initial begin
    bus.i_sclk   = 1'b0;
    bus.i_mosi   = 1'b0;
    bus.i_ss_n   = 1'b1;
    bus.i_commit = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("reset");
    chk("reset.err", 64'(bus.o_err), 64'(0));
    chk("reset.busy", 64'(bus.o_busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    send_frame("pos", 34, 2'b00, 16'h1234, 16'h5678, 1'b0, -1);
    commit("pos_commit");

    send_frame("trunc20", 20, 2'b01, 16'hAAAA, 16'h5555, 1'b0, -1);
    send_frame("long35", 35, 2'b01, 16'hAAAA, 16'h5555, 1'b0, -1);
    send_frame("cmd11", 34, 2'b11, 16'hAAAA, 16'h5555, 1'b0, -1);
    send_frame("empty", 0, 2'b00, 16'h0, 16'h0, 1'b0, -1);

    send_frame("fac1", 34, 2'b01, 16'h0100, 16'h0000, 1'b0, -1);
    send_frame("fac2", 34, 2'b01, 16'hFF00, 16'h0000, 1'b0, -1);
    commit("fac_commit");

    send_frame("vp1", 34, 2'b10, 16'h0040, 16'h0010, 1'b0, -1);
    send_frame("vp2_align", 34, 2'b10, 16'h0020, 16'h0008, 1'b1, -1);
    commit("vp_commit");

    send_frame("pos_split", 34, 2'b00, 16'h0C01, 16'h0D02, 1'b0, -1);
    send_frame("fac_vs_pos", 34, 2'b01, 16'h00F0, 16'h0F00, 1'b1, -1);
    commit("split_commit");

    send_frame("abort", 34, 2'b00, 16'h9999, 16'h8888, 1'b0, 17);
    send_frame("post_abort", 34, 2'b00, 16'h4321, 16'h8765, 1'b0, -1);
    commit("post_abort_commit");

    for (int n = 0; n < 14; n++) begin
      int          sel;
      int          len;
      logic [1:0]  cmd;
      sel = $urandom_range(0, 9);
      len = (sel <= 6) ? 34 : (sel == 7) ? 20 : (sel == 8) ? 35 : 0;
      cmd = 2'($urandom_range(0, 3));
      send_frame($sformatf("rnd%0d", n), len, cmd, 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0), -1);
      if ($urandom_range(0, 2) == 0) commit($sformatf("rnd%0d_commit", n));
    end
    commit("final_commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
